// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state codes,
// stream framing constants and the word address helper.
package imem_loader_pkg;

  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_HDR_HI = 3'd1;
  localparam logic [2:0] ENC_HDR_LO = 3'd2;
  localparam logic [2:0] ENC_DATA   = 3'd3;
  localparam logic [2:0] ENC_WRITE  = 3'd4;
  localparam logic [2:0] ENC_DONE   = 3'd5;
  localparam logic [2:0] ENC_ERR    = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = ENC_IDLE,
    ST_HDR_HI = ENC_HDR_HI,
    ST_HDR_LO = ENC_HDR_LO,
    ST_DATA   = ENC_DATA,
    ST_WRITE  = ENC_WRITE,
    ST_DONE   = ENC_DONE,
    ST_ERR    = ENC_ERR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // Byte address of word idx; wraps modulo 2^32.
  function automatic logic [31:0] word_adr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer: shifts accepted bytes into a 32-bit word
// and pulses word_full on the edge that takes the last byte of a word.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_full
);

  logic [31:0] shift_reg;
  logic [1:0]  cnt_reg;

  // word_next is the word as it will look once byte_in is shifted in, so the
  // owner can capture a complete word on the word_full edge.
  assign word_next = {shift_reg[23:0], byte_in};
  assign word_full = accept && (cnt_reg == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else if (accept) begin
      shift_reg <= word_next;
      cnt_reg   <= cnt_reg + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: parses a word-count header, packs the byte
// stream into words, writes them from BASE_ADR and holds fetch meanwhile.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADR    = 32'd0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [7:0]  BYTE_IN,
  input  logic        BYTE_VALID,
  output logic        BYTE_READY,
  output logic        MEM_WRITE,
  output logic [31:0] MEM_ADR,
  output logic [31:0] MEM_DATA,
  output logic        CPU_HOLD,
  output logic        DONE,
  output logic        ERROR
);

  localparam int IDX_W    = $clog2(DEPTH_WORDS) + 1;
  localparam int HDR_BITS = 8 * HDR_BYTES;

  state_t              state_reg, state_next;
  logic [7:0]          count_hi_reg;
  logic [HDR_BITS-1:0] count_reg;
  logic [IDX_W-1:0]    index_reg;
  logic [31:0]         adr_reg, data_reg;

  logic                accept;
  logic [HDR_BITS-1:0] hdr_count;
  logic                last_word;
  logic                packer_clear, packer_accept;
  logic [31:0]         word_next;
  logic                word_full;

  assign accept    = BYTE_VALID && BYTE_READY;
  assign hdr_count = {count_hi_reg, BYTE_IN};
  assign last_word = (32'(index_reg) + 32'd1) == 32'(count_reg);
  assign MEM_ADR   = adr_reg;
  assign MEM_DATA  = data_reg;

  imem_loader_byte_packer u_packer (
    .clk       (CLK),
    .srst      (RST),
    .clear     (packer_clear),
    .accept    (packer_accept),
    .byte_in   (BYTE_IN),
    .word_next (word_next),
    .word_full (word_full)
  );

  always_comb begin
    state_next    = state_reg;
    BYTE_READY    = 1'b0;
    CPU_HOLD      = 1'b0;
    MEM_WRITE     = 1'b0;
    DONE          = 1'b0;
    ERROR         = 1'b0;
    packer_clear  = 1'b0;
    packer_accept = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (START) state_next = ST_HDR_HI;
      end
      ST_HDR_HI: begin
        BYTE_READY = 1'b1;
        CPU_HOLD   = 1'b1;
        if (accept) state_next = ST_HDR_LO;
      end
      ST_HDR_LO: begin
        BYTE_READY = 1'b1;
        CPU_HOLD   = 1'b1;
        if (accept) begin
          if (hdr_count == '0) begin
            state_next = ST_DONE;
          end else if (int'(hdr_count) > DEPTH_WORDS) begin
            state_next = ST_ERR;
          end else begin
            state_next   = ST_DATA;
            packer_clear = 1'b1;
          end
        end
      end
      ST_DATA: begin
        BYTE_READY    = 1'b1;
        CPU_HOLD      = 1'b1;
        packer_accept = accept;
        if (word_full) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        CPU_HOLD  = 1'b1;
        MEM_WRITE = 1'b1;
        if (last_word) begin
          state_next = ST_DONE;
        end else begin
          state_next   = ST_DATA;
          packer_clear = 1'b1;
        end
      end
      ST_DONE: begin
        DONE = 1'b1;
        if (START) state_next = ST_HDR_HI;
      end
      ST_ERR: begin
        ERROR    = 1'b1;
        CPU_HOLD = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= ST_IDLE;
      count_hi_reg <= '0;
      count_reg    <= '0;
      index_reg    <= '0;
      adr_reg      <= '0;
      data_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_HDR_HI && accept) count_hi_reg <= BYTE_IN;
      if (state_reg == ST_HDR_LO && accept) begin
        count_reg <= hdr_count;
        index_reg <= '0;
      end
      // Address and data are captured as the word completes so they are
      // already stable during the WRITE cycle and hold afterwards.
      if (word_full) begin
        adr_reg  <= word_adr(BASE_ADR, 32'(index_reg));
        data_reg <= word_next;
      end
      if (state_reg == ST_WRITE) index_reg <= index_reg + 1'b1;
    end
  end

endmodule
